// File: rtl/delay_pulse_bank.sv
// Purpose: bank of NCH independent trigger-to-pulse delay channels. Each channel
// waits for a falling edge on its trigger, counts a per-channel delay, then emits
// a fixed-width pulse followed by a one-clock completion strobe.
// Ports:
//   clk     - sole clock, rising edge
//   rst     - asynchronous active-high reset
//   trig    - per-channel trigger level; a 1->0 transition fires the channel
//   dly     - per-channel delay, channel i uses dly[i*CW +: CW]
//   retrig  - per-channel retrigger enable (an edge during delay restarts timing)
//   clr     - per-channel synchronous abort
//   busy    - channel in delay or pulse phase
//   pulse   - delayed output pulse, PW clocks wide
//   done    - one-clock strobe after the pulse ends
module delay_pulse_bank #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 8,
  parameter int unsigned PW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    trig,
  input  logic [NCH*CW-1:0] dly,
  input  logic [NCH-1:0]    retrig,
  input  logic [NCH-1:0]    clr,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    pulse,
  output logic [NCH-1:0]    done
);

  // Width counter holds PW-1 down to 0, so it needs clog2(PW) bits (at least one).
  localparam int unsigned WW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [WW-1:0] W_LOAD = WW'(PW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_PULSE = 2'd2
  } state_e;

  logic [NCH-1:0] trig_q;
  logic [NCH-1:0] edge_c;

  // Previous trigger level; reset to 0 so a trigger held low through reset does not fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q <= '0;
    end else begin
      trig_q <= trig;
    end
  end

  assign edge_c = trig_q & ~trig;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [CW-1:0]   dly_c;
    logic            done_d;
    logic            busy_q, pulse_q, done_q;

    assign dly_c = dly[g*CW +: CW];

    // Channel state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        wcnt_q  <= '0;
        busy_q  <= 1'b0;
        pulse_q <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        wcnt_q  <= wcnt_d;
        busy_q  <= (state_d != S_IDLE);
        pulse_q <= (state_d == S_PULSE);
        done_q  <= done_d;
      end
    end

    // Next-state logic; clr wins over any edge in the same clock.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      done_d  = 1'b0;
      if (clr[g]) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        wcnt_d  = '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (edge_c[g]) begin
              if (dly_c == '0) begin
                state_d = S_PULSE;
                wcnt_d  = W_LOAD;
              end else begin
                state_d = S_DELAY;
                cnt_d   = dly_c;
              end
            end
          end
          S_DELAY: begin
            // A retrigger reload takes priority over the terminal count.
            if (edge_c[g] && retrig[g]) begin
              cnt_d = dly_c;
            end else if (cnt_q <= CW'(1)) begin
              state_d = S_PULSE;
              cnt_d   = '0;
              wcnt_d  = W_LOAD;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
          S_PULSE: begin
            if (wcnt_q == '0) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              wcnt_d = wcnt_q - WW'(1);
            end
          end
          default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            wcnt_d  = '0;
          end
        endcase
      end
    end

    assign busy[g]  = busy_q;
    assign pulse[g] = pulse_q;
    assign done[g]  = done_q;
  end

endmodule

// File: tb/tb_delay_pulse_bank.sv
// Scoreboard bench for delay_pulse_bank: stimulus pushes the expected cycle of
// each output transition per channel; a monitor pops on every observed transition.
module tb_delay_pulse_bank;
  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int PW  = 3;
  localparam int NK  = 6; // busy rise/fall, pulse rise/fall, done rise/fall

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NCH-1:0]    trig;
  logic [NCH*CW-1:0] dly;
  logic [NCH-1:0]    retrig;
  logic [NCH-1:0]    clr;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    pulse;
  logic [NCH-1:0]    done;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int exp_q[NCH*NK][$];
  logic fin_req = 1'b0;
  logic mon_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  delay_pulse_bank #(.NCH(NCH), .CW(CW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .trig(trig), .dly(dly), .retrig(retrig),
    .clr(clr), .busy(busy), .pulse(pulse), .done(done)
  );

  function automatic string kname(input int k);
    case (k)
      0: return "busy_rise";
      1: return "busy_fall";
      2: return "pulse_rise";
      3: return "pulse_fall";
      4: return "done_rise";
      default: return "done_fall";
    endcase
  endfunction

  function automatic void push_ev(input int ch, input int k, input int c);
    exp_q[ch*NK+k].push_back(c);
  endfunction

  // Complete run from an edge at e0 with effective delay d.
  function automatic void expect_run(input int ch, input int e0, input int d);
    push_ev(ch, 0, e0);
    push_ev(ch, 2, e0 + d);
    push_ev(ch, 3, e0 + d + PW);
    push_ev(ch, 1, e0 + d + PW);
    push_ev(ch, 4, e0 + d + PW);
    push_ev(ch, 5, e0 + d + PW + 1);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    for (int i = 0; i < 1000 && cyc < c; i++) @(negedge clk);
  endtask

  // Monitor: the only process that compares and counts.
  initial begin : monitor
    logic [NCH-1:0] busy_p, pulse_p, done_p;
    logic [NK-1:0]  ev;
    int             e;
    busy_p = '0; pulse_p = '0; done_p = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        checks++;
        if ({busy, pulse, done} != '0) begin
          errors++;
          $display("FAIL reset_outputs cycle %0d: got busy=%b pulse=%b done=%b, required all 0",
                   cyc, busy, pulse, done);
        end
      end
      for (int ch = 0; ch < NCH; ch++) begin
        ev[0] = busy[ch] & ~busy_p[ch];
        ev[1] = ~busy[ch] & busy_p[ch];
        ev[2] = pulse[ch] & ~pulse_p[ch];
        ev[3] = ~pulse[ch] & pulse_p[ch];
        ev[4] = done[ch] & ~done_p[ch];
        ev[5] = ~done[ch] & done_p[ch];
        for (int k = 0; k < NK; k++) begin
          if (ev[k]) begin
            checks++;
            if (exp_q[ch*NK+k].size() == 0) begin
              errors++;
              $display("FAIL %s ch%0d: unexpected event at cycle %0d, required none",
                       kname(k), ch, cyc);
            end else begin
              e = exp_q[ch*NK+k].pop_front();
              if (e != cyc) begin
                errors++;
                $display("FAIL %s ch%0d: event at cycle %0d, required cycle %0d",
                         kname(k), ch, cyc, e);
              end
            end
          end
        end
      end
      busy_p = busy; pulse_p = pulse; done_p = done;
      if (fin_req && !mon_done) begin
        for (int q = 0; q < NCH*NK; q++) begin
          checks++;
          if (exp_q[q].size() != 0) begin
            errors++;
            $display("FAIL %s ch%0d: missing event, required cycle %0d",
                     kname(q % NK), q / NK, exp_q[q][0]);
          end
        end
        mon_done = 1'b1;
      end
    end
  end

  initial begin : stim
    int e0;
    trig = '0; dly = '0; retrig = '0; clr = '0;
    #1 rst = 1'b1;
    step(3);
    rst = 1'b0;
    // Trigger held low through reset release must not fire.
    step(4);
    trig = '1;
    step(2);

    // Basic delay on ch0 and zero delay on ch1, same clock.
    dly[0*CW +: CW] = 8'd5;
    dly[1*CW +: CW] = 8'd0;
    e0 = cyc + 1;
    trig[0] = 1'b0; trig[1] = 1'b0;
    expect_run(0, e0, 5);
    expect_run(1, e0, 0);
    step(1);
    dly[0*CW +: CW] = 8'd50; // must not disturb the running delay
    trig[1:0] = 2'b11;
    step(1);
    dly[0*CW +: CW] = 8'd5;
    // Back-to-back: new edge lands in the clock where done0 is high.
    wait_cyc(e0 + 8);
    trig[0] = 1'b0;
    expect_run(0, e0 + 9, 5);
    step(1);
    trig[0] = 1'b1;
    step(16);

    // Retrigger on ch2: second edge at e0+4 restarts a 10-clock delay.
    dly[2*CW +: CW] = 8'd10;
    retrig[2] = 1'b1;
    e0 = cyc + 1;
    trig[2] = 1'b0;
    expect_run(2, e0, 14);
    step(1); trig[2] = 1'b1;
    wait_cyc(e0 + 3); trig[2] = 1'b0;
    step(1); trig[2] = 1'b1;
    step(20);

    // Same with retrigger off; edges in DELAY and in PULSE are ignored.
    retrig[2] = 1'b0;
    e0 = cyc + 1;
    trig[2] = 1'b0;
    expect_run(2, e0, 10);
    step(1); trig[2] = 1'b1;
    wait_cyc(e0 + 3); trig[2] = 1'b0;
    step(1); trig[2] = 1'b1;
    wait_cyc(e0 + 11); trig[2] = 1'b0;
    step(1); trig[2] = 1'b1;
    step(10);

    // clr with a retrigger edge during DELAY on ch3; ch2 fires in the same clock.
    dly[3*CW +: CW] = 8'd20;
    dly[2*CW +: CW] = 8'd3;
    retrig[3] = 1'b1;
    e0 = cyc + 1;
    trig[3] = 1'b0;
    push_ev(3, 0, e0);
    push_ev(3, 1, e0 + 5);
    step(1); trig[3] = 1'b1;
    wait_cyc(e0 + 4);
    trig[3] = 1'b0; clr[3] = 1'b1;
    trig[2] = 1'b0;
    expect_run(2, e0 + 5, 3);
    step(1);
    clr[3] = 1'b0; trig[3] = 1'b1; trig[2] = 1'b1;
    step(25);

    // Asynchronous reset while pulse0 is high, trig0 held low afterwards.
    dly[0*CW +: CW] = 8'd2;
    e0 = cyc + 1;
    trig[0] = 1'b0;
    push_ev(0, 0, e0);
    push_ev(0, 2, e0 + 2);
    wait_cyc(e0 + 2);
    @(posedge clk);
    #1;
    push_ev(0, 3, e0 + 3);
    push_ev(0, 1, e0 + 3);
    rst = 1'b1;
    @(negedge clk);
    step(1);
    rst = 1'b0;
    step(5);
    trig[0] = 1'b1;
    step(1);
    e0 = cyc + 1;
    trig[0] = 1'b0;
    expect_run(0, e0, 2);
    step(1);
    trig[0] = 1'b1;
    step(12);

    fin_req = 1'b1;
    for (int i = 0; i < 10 && !mon_done; i++) @(negedge clk);
    if (!mon_done) begin
      $display("FAIL monitor_finish: got no completion, required completion within 10 cycles");
      $fatal(1, "monitor did not complete");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
